dmaster_stream_arbiter: RTL and testbench

//  Round-robin, packet-locked arbiter sharing the 8-bit Avalon-ST byte channel into the

---
 rtl/dmaster_stream_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmaster_stream_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmaster_stream_arbiter.sv
// Round-robin, packet-locked arbiter muxing NUM_IN byte streams onto one Avalon-ST channel.
// Latency: 1 cycle arbitration (IDLE->LOCK), then 1 cycle per beat into the registered output stage.
// Backpressure: owner's in_ready follows output-stage-free; output beat held while out_valid & !out_ready.
module dmaster_stream_arbiter #(
    parameter int NUM_IN      = 2,
    parameter int MAX_PKT_LEN = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_IN-1:0]     in_valid,
    input  logic [8*NUM_IN-1:0]   in_data,
    input  logic [NUM_IN-1:0]     in_sop,
    input  logic [NUM_IN-1:0]     in_eop,
    output logic [NUM_IN-1:0]     in_ready,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    input  logic                  out_ready,
    output logic [NUM_IN-1:0]     grant,
    output logic                  err_len,
    output logic                  err_stray
);

    localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int CW = $clog2(MAX_PKT_LEN + 1);

    typedef enum logic {IDLE, LOCK} state_t;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] dat;
    } beat_t;

    state_t              state, state_n;
    logic [NUM_IN-1:0]   grant_n;
    logic [IW-1:0]       last_grant, last_grant_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic                out_vld, out_vld_n;
    beat_t               out_beat, out_beat_n;
    logic                err_len_n, err_stray_n;
    logic [NUM_IN-1:0]   ready_c;

    logic [NUM_IN-1:0]   sop_req;
    logic                found;
    logic [IW-1:0]       win_idx, cand;
    logic [IW-1:0]       owner_idx;
    beat_t               sel_beat;
    logic                out_free;
    logic                wd_hit;

    assign sop_req  = in_valid & in_sop;
    assign out_free = !out_vld || out_ready;
    assign wd_hit   = (cnt == CW'(MAX_PKT_LEN - 1));

    // Search starts one past the last owner so every requester gets a turn.
    always_comb begin : p_arb
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            cand = IW'((int'(last_grant) + k) % NUM_IN);
            if (!found && sop_req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin : p_sel
        owner_idx = '0;
        sel_beat  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                owner_idx = IW'(i);
                sel_beat  = '{sop: in_sop[i], eop: in_eop[i], dat: in_data[8*i +: 8]};
            end
        end
    end

    always_comb begin : p_next
        state_n      = state;
        grant_n      = grant;
        last_grant_n = last_grant;
        cnt_n        = cnt;
        out_vld_n    = out_vld && !out_ready;
        out_beat_n   = out_beat;
        err_len_n    = 1'b0;
        err_stray_n  = 1'b0;
        ready_c      = '0;
        case (state)
            IDLE: begin
                // Non-SOP beats arriving with no owner are orphans; drop them.
                ready_c     = in_valid & ~in_sop;
                err_stray_n = |ready_c;
                if (found) begin
                    grant_n = NUM_IN'(1) << win_idx;
                    state_n = LOCK;
                end
            end
            LOCK: begin
                ready_c = grant & {NUM_IN{out_free}};
                if (|(ready_c & in_valid)) begin
                    out_vld_n  = 1'b1;
                    out_beat_n = sel_beat;
                    cnt_n      = cnt + CW'(1);
                    if (sel_beat.eop || wd_hit) begin
                        out_beat_n.eop = 1'b1;
                        err_len_n      = wd_hit && !sel_beat.eop;
                        grant_n        = '0;
                        last_grant_n   = owner_idx;
                        cnt_n          = '0;
                        state_n        = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Gated by reset so nothing is acknowledged while the block is held in reset.
    assign in_ready = ready_c & {NUM_IN{reset_n}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IW'(NUM_IN - 1);
            cnt        <= '0;
            out_vld    <= 1'b0;
            out_beat   <= '0;
            err_len    <= 1'b0;
            err_stray  <= 1'b0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_grant <= last_grant_n;
            cnt        <= cnt_n;
            out_vld    <= out_vld_n;
            out_beat   <= out_beat_n;
            err_len    <= err_len_n;
            err_stray  <= err_stray_n;
        end
    end

    assign out_valid = out_vld;
    assign out_data  = out_beat.dat;
    assign out_sop   = out_beat.sop;
    assign out_eop   = out_beat.eop;

endmodule

// File: tb/tb_dmaster_stream_arbiter.sv
// Directed bench for dmaster_stream_arbiter with NUM_IN=2, MAX_PKT_LEN=4.
module tb_dmaster_stream_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  in_valid, in_sop, in_eop, in_ready, grant;
    logic [15:0] in_data;
    logic        out_valid, out_sop, out_eop, out_ready, err_len, err_stray;
    logic [7:0]  out_data;

    dmaster_stream_arbiter #(.NUM_IN(2), .MAX_PKT_LEN(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .out_ready(out_ready), .grant(grant), .err_len(err_len), .err_stray(err_stray)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_len = 0;
    int n_stray = 0;
    int bad_onehot = 0;
    int bad_gap = 0;
    logic [1:0] prev_grant = 2'b00;
    logic [1:0] fire;

    // beat = {sop, eop, data}
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] q_out[$];
    logic [9:0] exp_q[$];
    logic [1:0] q_gnt[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic present();
        logic [9:0] b0, b1;
        b0 = (q0.size() != 0) ? q0[0] : 10'h000;
        b1 = (q1.size() != 0) ? q1[0] : 10'h000;
        in_valid = {q1.size() != 0, q0.size() != 0};
        in_sop   = {b1[9], b0[9]};
        in_eop   = {b1[8], b0[8]};
        in_data  = {b1[7:0], b0[7:0]};
    endtask

    task automatic push_pkt(input int src, input logic [7:0] first, input int len, input logic with_eop);
        logic [9:0] b;
        logic [7:0] d;
        for (int k = 0; k < len; k++) begin
            d = first + 8'(k);
            b = {k == 0, with_eop && (k == len - 1), d};
            if (src == 0) q0.push_back(b);
            else          q1.push_back(b);
        end
    endtask

    // Observe at the falling edge, advance to just after the next rising edge.
    task automatic step();
        @(negedge clk);
        fire = in_valid & in_ready;
        if (out_valid && out_ready) q_out.push_back({out_sop, out_eop, out_data});
        if (err_len)   n_len++;
        if (err_stray) n_stray++;
        if (grant == 2'b11) bad_onehot++;
        if (grant != 2'b00 && prev_grant != 2'b00 && grant != prev_grant) bad_gap++;
        if (grant != 2'b00 && prev_grant == 2'b00) q_gnt.push_back(grant);
        prev_grant = grant;
        @(posedge clk);
        #1;
        if (fire[0]) void'(q0.pop_front());
        if (fire[1]) void'(q1.pop_front());
        present();
    endtask

    task automatic run_idle(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            done = (q0.size() == 0) && (q1.size() == 0) && !out_valid && (grant == 2'b00);
        end
        step();
        step();
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic check_beats(input string tag);
        logic [9:0] obs;
        chk({tag, "_count"}, q_out.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (i < q_out.size()) ? q_out[i] : 10'h3FF;
            chk($sformatf("%s_beat%0d", tag, i), {22'd0, obs}, {22'd0, exp_q[i]});
        end
    endtask

    initial begin
        logic [7:0] bases [4];
        logic [1:0] gexp  [4];
        bases = '{8'h01, 8'h81, 8'h04, 8'h84};
        gexp  = '{2'b01, 2'b10, 2'b01, 2'b10};

        // Reset with every source asserting a non-SOP beat.
        reset_n   = 1'b0;
        out_ready = 1'b1;
        in_valid  = 2'b11;
        in_sop    = 2'b00;
        in_eop    = 2'b00;
        in_data   = 16'hBEEF;
        #22;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_in_ready", {30'd0, in_ready}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_err", {30'd0, err_len, err_stray}, 32'd0);
        present();
        #1 reset_n = 1'b1;
        step();

        // Fairness: two 3-byte packets per source, expect 0,1,0,1.
        q_out.delete(); q_gnt.delete(); exp_q.delete();
        push_pkt(0, 8'h01, 3, 1'b1);
        push_pkt(0, 8'h04, 3, 1'b1);
        push_pkt(1, 8'h81, 3, 1'b1);
        push_pkt(1, 8'h84, 3, 1'b1);
        present();
        run_idle("fair");
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 3; k++)
                exp_q.push_back({k == 0, k == 2, bases[p] + 8'(k)});
        check_beats("fair");
        chk("fair_grants", q_gnt.size(), 4);
        for (int p = 0; p < 4; p++)
            chk($sformatf("fair_grant%0d", p), {30'd0, (p < q_gnt.size()) ? q_gnt[p] : 2'b11}, {30'd0, gexp[p]});
        chk("fair_onehot", bad_onehot, 0);
        chk("fair_gap", bad_gap, 0);
        chk("fair_no_err", n_len + n_stray, 0);

        // Backpressure: stall output for 5 cycles right after the first byte.
        q_out.delete(); exp_q.delete();
        q0.push_back({2'b10, 8'h11});
        q0.push_back({2'b00, 8'h22});
        q0.push_back({2'b01, 8'h33});
        present();
        step();
        chk("bp_grant", {30'd0, grant}, 32'd1);
        step();
        chk("bp_first", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h11});
        out_ready = 1'b0;
        #1;
        chk("bp_ready_drop", {30'd0, in_ready}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("bp_vld%0d", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp_dat%0d", c), {24'd0, out_data}, 32'h11);
            chk($sformatf("bp_rdy%0d", c), {30'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        run_idle("bp");
        exp_q.push_back({2'b10, 8'h11});
        exp_q.push_back({2'b00, 8'h22});
        exp_q.push_back({2'b01, 8'h33});
        check_beats("bp");

        // Watchdog: 6 bytes, no EOP, limit 4.
        q_out.delete(); exp_q.delete();
        n_len = 0; n_stray = 0;
        push_pkt(0, 8'hC1, 6, 1'b0);
        present();
        run_idle("wd");
        exp_q.push_back({2'b10, 8'hC1});
        exp_q.push_back({2'b00, 8'hC2});
        exp_q.push_back({2'b00, 8'hC3});
        exp_q.push_back({2'b01, 8'hC4});
        check_beats("wd");
        chk("wd_err_len", n_len, 1);
        chk("wd_err_stray", n_stray, 2);

        // Single-byte packet on source 1.
        q_out.delete();
        q1.push_back({2'b11, 8'hA5});
        present();
        #1;
        chk("one_sop_pending", {30'd0, in_ready}, 32'd0);
        step();
        chk("one_grant", {30'd0, grant}, 32'd2);
        chk("one_ready", {30'd0, in_ready}, 32'd2);
        step();
        chk("one_beat", {21'd0, out_valid, out_sop, out_eop, out_data}, {21'd0, 3'b111, 8'hA5});
        chk("one_release", {30'd0, grant}, 32'd0);
        step();
        chk("one_done", {31'd0, out_valid}, 32'd0);

        // Reset while locked mid-packet.
        push_pkt(1, 8'h51, 3, 1'b1);
        present();
        step();
        step();
        chk("mrst_pre_grant", {30'd0, grant}, 32'd2);
        chk("mrst_pre_vld", {31'd0, out_valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mrst_vld", {31'd0, out_valid}, 32'd0);
        chk("mrst_grant", {30'd0, grant}, 32'd0);
        chk("mrst_out", {22'd0, out_sop, out_eop, out_data}, 32'd0);
        chk("mrst_ready", {30'd0, in_ready}, 32'd0);
        q1.delete();
        present();
        #1 reset_n = 1'b1;
        step();
        chk("post_rst_idle", {29'd0, out_valid, grant}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
